fp_compare: RTL and testbench
=============================

Name: fp_compare

Overview:
- Registered IEEE-754 single-precision comparator. Takes two 32-bit floats and reports a>=b (geq) and a<=b (leq), plus an unordered flag for NaN operands.
- Used by the synth datapath wherever float ordering is needed, for example clamping and threshold tests.
- Outputs are registered. Equality is reported as geq=leq=1.

Parameters:
- STAGES, 1, pipeline depth in clock cycles from inputs to outputs.
  - 1 = output register only.
  - 2 = input register plus output register.
  - Other values are illegal; elaboration must fail.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies dataa/datab this cycle.
- dataa  input  32  operand A, IEEE-754 binary32 (sign[31], exp[30:23], frac[22:0]).
- datab  input  32  operand B, same format.
- out_valid  output  1  in_valid delayed by STAGES cycles.
- geq  output  1  A >= B.
- leq  output  1  A <= B.
- unordered  output  1  at least one operand is NaN.

Behaviour:
- Reset:
  - Asserting reset asynchronously clears every pipeline register: out_valid=0, geq=0, leq=0, unordered=0.
  - Reset mid-stream discards all in-flight comparisons; no output pulse follows deassertion.
- Latency and throughput:
  - Result for inputs sampled at edge N appears on the outputs after edge N+STAGES-1.
  - One comparison per cycle, no backpressure.
  - Data registers update every cycle regardless of in_valid; out_valid only tracks in_valid.
- Classification per operand:
  - NaN: exp=0xFF and frac!=0.
  - Zero: exp=0 and frac=0.
  - Infinities and denormals are ordinary ordered values.
  - Denormals are compared exactly, with no flush-to-zero.
- Comparison logic (combinational core), where mag = bits[30:0] as unsigned:
  - If either operand is NaN: geq=0, leq=0, unordered=1.
  - Else if both are zero, any signs (+0 vs -0 included): equal.
  - Else if the bit patterns are identical: equal.
  - Else if signs differ: the operand with sign=0 is greater.
  - Else if both are positive: greater = larger mag.
  - Else (both negative): greater = smaller mag.
  - Outputs: equal gives geq=1, leq=1. A greater gives geq=1, leq=0. B greater gives geq=0, leq=1.
  - unordered=0 whenever neither operand is NaN.
- Invariant: geq, leq and unordered are never all 1; unordered=1 implies geq=leq=0.
- The core is a 31-bit unsigned magnitude compare plus sign/zero/NaN muxing. No subtraction or normalisation.

Test Plan:
- Zeros and equality:
  - A=0x80000000 (-0), B=0x00000000 (+0) -> {geq,leq}=11.
  - A=B=0x3FC00000 (1.5) -> 11, unordered=0.
- Same-sign ordering:
  - A=0x3FCCCCCD (1.6), B=0x3FC00000 -> 10, and swapped -> 01.
  - A=0x40200000 (2.5), B=0x3FC00000 -> 10, and swapped -> 01.
  - A=0x40033613 (2.0502), B=0x40490FDB (pi) -> 01.
- Sign handling:
  - A=0x3FC00000, B=0xBFC00000 -> 10, and swapped -> 01.
  - A=0xBFC00000 (-1.5), B=0xBFCCCCCD (-1.6) -> 10, and swapped -> 01.
- Specials:
  - A=0x7FC00000 (NaN) vs any B -> geq=leq=0, unordered=1.
  - A=0x7F800000 (+inf), B=0x7F7FFFFF -> 10.
  - A=0x00000001 (denormal), B=0x00000000 -> 10.
- Timing and reset:
  - Stream back-to-back vectors with in_valid=1 -> each result and out_valid appear exactly STAGES cycles later.
  - Check both STAGES=1 and STAGES=2.
  - Assert reset mid-stream -> all outputs 0 immediately, before any clock edge, and out_valid stays 0 until new valid inputs propagate.

Source files
------------

// File: rtl/fp_compare.sv
// Registered IEEE-754 binary32 comparator producing a>=b, a<=b and an unordered flag.
// STAGES selects output-register-only (1) or input plus output registers (2).
module fp_compare #(
  parameter int STAGES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        out_valid,
  output logic        geq,
  output logic        leq,
  output logic        unordered
);

  typedef struct packed {
    logic geq;
    logic leq;
    logic unordered;
  } cmp_res_t;

  localparam cmp_res_t RES_EQ  = '{geq: 1'b1, leq: 1'b1, unordered: 1'b0};
  localparam cmp_res_t RES_GT  = '{geq: 1'b1, leq: 1'b0, unordered: 1'b0};
  localparam cmp_res_t RES_LT  = '{geq: 1'b0, leq: 1'b1, unordered: 1'b0};
  localparam cmp_res_t RES_NAN = '{geq: 1'b0, leq: 1'b0, unordered: 1'b1};

  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        valid_s;

  generate
    if (STAGES == 2) begin : g_in_reg
      logic [31:0] a_q, b_q;
      logic        valid_q;

      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; the async reset is in the sensitivity list.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q     <= '0;
          b_q     <= '0;
          valid_q <= 1'b0;
        end else begin
          a_q     <= dataa;
          b_q     <= datab;
          valid_q <= in_valid;
        end
      end

      assign a_s     = a_q;
      assign b_s     = b_q;
      assign valid_s = valid_q;
    end else if (STAGES == 1) begin : g_no_in_reg
      assign a_s     = dataa;
      assign b_s     = datab;
      assign valid_s = in_valid;
    end else begin : g_bad_stages
      $error("fp_compare: STAGES must be 1 or 2");
    end
  endgenerate

  logic     nan_a, nan_b, zero_a, zero_b, mag_a_gt;
  cmp_res_t res_d, res_q;
  logic     valid_q;

  assign nan_a    = (&a_s[30:23]) & (|a_s[22:0]);
  assign nan_b    = (&b_s[30:23]) & (|b_s[22:0]);
  assign zero_a   = ~|a_s[30:0];
  assign zero_b   = ~|b_s[30:0];
  assign mag_a_gt = a_s[30:0] > b_s[30:0];

  // Priority order matters: NaN beats identical bits, signed zeros compare equal.
  always_comb begin
    res_d = RES_EQ;
    if (nan_a || nan_b) begin
      res_d = RES_NAN;
    end else if ((zero_a && zero_b) || (a_s == b_s)) begin
      res_d = RES_EQ;
    end else if (a_s[31] != b_s[31]) begin
      res_d = a_s[31] ? RES_LT : RES_GT;
    end else if (!a_s[31]) begin
      res_d = mag_a_gt ? RES_GT : RES_LT;
    end else begin
      res_d = mag_a_gt ? RES_LT : RES_GT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_s;
    end
  end

  assign out_valid = valid_q;
  assign geq       = res_q.geq;
  assign leq       = res_q.leq;
  assign unordered = res_q.unordered;

endmodule

// File: tb/tb_fp_compare.sv
// Directed bench for fp_compare: STAGES=1 and STAGES=2 instances share one input stream.
module tb_fp_compare;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;

  logic ov1, g1, l1, u1;
  logic ov2, g2, l2, u2;

  int total = 0;
  int bad   = 0;

  fp_compare #(.STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .dataa(dataa), .datab(datab),
    .out_valid(ov1), .geq(g1), .leq(l1), .unordered(u1)
  );

  fp_compare #(.STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .dataa(dataa), .datab(datab),
    .out_valid(ov2), .geq(g2), .leq(l2), .unordered(u2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  e;   // {geq, leq, unordered}
  } vec_t;

  localparam int N = 18;
  vec_t vecs [0:N-1];

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h80000000, 32'h00000000, 3'b110};  // -0 vs +0
    vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 3'b110};  // 1.5 == 1.5
    vecs[2]  = '{32'h3FCCCCCD, 32'h3FC00000, 3'b100};  // 1.6 > 1.5
    vecs[3]  = '{32'h3FC00000, 32'h3FCCCCCD, 3'b010};
    vecs[4]  = '{32'h40200000, 32'h3FC00000, 3'b100};  // 2.5 > 1.5
    vecs[5]  = '{32'h3FC00000, 32'h40200000, 3'b010};
    vecs[6]  = '{32'h40033613, 32'h40490FDB, 3'b010};  // 2.0502 < pi
    vecs[7]  = '{32'h3FC00000, 32'hBFC00000, 3'b100};  // 1.5 > -1.5
    vecs[8]  = '{32'hBFC00000, 32'h3FC00000, 3'b010};
    vecs[9]  = '{32'hBFC00000, 32'hBFCCCCCD, 3'b100};  // -1.5 > -1.6
    vecs[10] = '{32'hBFCCCCCD, 32'hBFC00000, 3'b010};
    vecs[11] = '{32'h7FC00000, 32'h3F800000, 3'b001};  // NaN in A
    vecs[12] = '{32'h3F800000, 32'h7FC00000, 3'b001};  // NaN in B
    vecs[13] = '{32'h7F800000, 32'h7F7FFFFF, 3'b100};  // +inf > max finite
    vecs[14] = '{32'h00000001, 32'h00000000, 3'b100};  // min denormal > +0
    vecs[15] = '{32'h00000000, 32'h80000001, 3'b100};  // +0 > -denormal
    vecs[16] = '{32'hFF800000, 32'h7F800000, 3'b010};  // -inf < +inf
    vecs[17] = '{32'h7F800001, 32'h7F800001, 3'b001};  // identical NaN bits

    // Reset from time 0, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_init_s1", {ov1, g1, l1, u1}, 4'b0000);
    check("rst_init_s2", {ov2, g2, l2, u2}, 4'b0000);
    @(posedge clk);
    #1 reset = 1'b0;

    // Back-to-back stream; STAGES=1 shows vector i after its sampling edge,
    // STAGES=2 shows vector i-1 at the same point.
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        in_valid = 1'b1;
        dataa    = vecs[i].a;
        datab    = vecs[i].b;
      end else begin
        in_valid = 1'b0;
        dataa    = '0;
        datab    = '0;
      end
      @(posedge clk);
      #1;
      if (i < N) check($sformatf("s1_vec%0d", i), {ov1, g1, l1, u1}, {1'b1, vecs[i].e});
      else       check("s1_tail_valid", {3'b000, ov1}, 4'b0000);
      if (i > 0) check($sformatf("s2_vec%0d", i-1), {ov2, g2, l2, u2}, {1'b1, vecs[i-1].e});
      else       check("s2_first_valid", {3'b000, ov2}, 4'b0000);
    end

    // Mid-stream reset: outputs clear asynchronously, before the next edge.
    for (int i = 2; i < 5; i++) begin
      in_valid = 1'b1;
      dataa    = vecs[i].a;
      datab    = vecs[i].b;
      @(posedge clk);
      #1;
    end
    check("pre_rst_s1", {ov1, g1, l1, u1}, {1'b1, vecs[4].e});
    check("pre_rst_s2", {ov2, g2, l2, u2}, {1'b1, vecs[3].e});
    #2 reset = 1'b1;
    #1;
    check("rst_async_s1", {ov1, g1, l1, u1}, 4'b0000);
    check("rst_async_s2", {ov2, g2, l2, u2}, 4'b0000);
    in_valid = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;

    // No pulse after deassertion while in_valid stays low.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_idle%0d", i), {2'b00, ov1, ov2}, 4'b0000);
    end

    // A fresh valid vector propagates with each instance's latency.
    in_valid = 1'b1;
    dataa    = vecs[9].a;
    datab    = vecs[9].b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("restart_s1", {ov1, g1, l1, u1}, {1'b1, vecs[9].e});
    check("restart_s2_pending", {3'b000, ov2}, 4'b0000);
    @(posedge clk);
    #1;
    check("restart_s2", {ov2, g2, l2, u2}, {1'b1, vecs[9].e});
    check("restart_s1_drop", {3'b000, ov1}, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
